// File: rtl/key_event_pulser_pkg.sv
`default_nettype none
// == key_event_pulser_pkg : PS/2 key codes, key bit indices, priority grant == Rev 1.0
package key_event_pulser_pkg;

  localparam int NKEYS = 5;

  localparam logic [8:0] KEY_W     = 9'h01D;
  localparam logic [8:0] KEY_A     = 9'h01C;
  localparam logic [8:0] KEY_S     = 9'h01B;
  localparam logic [8:0] KEY_D     = 9'h023;
  localparam logic [8:0] KEY_ENTER = 9'h05A;

  localparam int KIDX_UP = 0;
  localparam int KIDX_LT = 1;
  localparam int KIDX_DW = 2;
  localparam int KIDX_RT = 3;
  localparam int KIDX_CT = 4;

  typedef logic [NKEYS-1:0] key_vec_t;

  function automatic logic [8:0] key_code(input int idx);
    logic [8:0] code;
    case (idx)
      KIDX_UP: code = KEY_W;
      KIDX_LT: code = KEY_A;
      KIDX_DW: code = KEY_S;
      KIDX_RT: code = KEY_D;
      default: code = KEY_ENTER;
    endcase
    return code;
  endfunction

  // Fixed priority ct > up > dw > lt > rt, one-hot result.
  function automatic key_vec_t prio_grant(input key_vec_t req);
    key_vec_t g;
    g = '0;
    if (req[KIDX_CT])      g[KIDX_CT] = 1'b1;
    else if (req[KIDX_UP]) g[KIDX_UP] = 1'b1;
    else if (req[KIDX_DW]) g[KIDX_DW] = 1'b1;
    else if (req[KIDX_LT]) g[KIDX_LT] = 1'b1;
    else if (req[KIDX_RT]) g[KIDX_RT] = 1'b1;
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_pulser_if.sv
`default_nettype none
// == key_event_pulser_if : decoder-side inputs and pulse outputs of key_event_pulser == Rev 1.0
interface key_event_pulser_if;
  import key_event_pulser_pkg::*;

  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         enable;
  logic         up_pulse;
  logic         lt_pulse;
  logic         dw_pulse;
  logic         rt_pulse;
  logic         ct_pulse;
  key_vec_t     key_held;

  modport master (
    output key_down, last_change, key_valid, enable,
    input  up_pulse, lt_pulse, dw_pulse, rt_pulse, ct_pulse, key_held
  );

  modport slave (
    input  key_down, last_change, key_valid, enable,
    output up_pulse, lt_pulse, dw_pulse, rt_pulse, ct_pulse, key_held
  );

endinterface
`default_nettype wire

// File: rtl/key_event_pulser_repeat_fsm.sv
`default_nettype none
// == key_repeat_fsm : per-key IDLE/DELAY/REPEAT tracker producing pending-set ticks == Rev 1.0
module key_repeat_fsm #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 15_000_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic rel,
  input  logic rep_en,
  output logic tick,
  output logic held
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Release wins over any tick due in the same cycle.
  always_comb begin
    tick = 1'b0;
    if (!rel) begin
      case (state)
        ST_IDLE:   tick = press;
        ST_DELAY:  tick = rep_en && (cnt == DELAY_LAST);
        ST_REPEAT: tick = (cnt == PERIOD_LAST);
        default:   tick = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (rel) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press) begin
            state <= ST_DELAY;
            cnt   <= '0;
          end
        end
        ST_DELAY: begin
          // Without repeat the counter parks at the threshold instead of wrapping.
          if (rep_en && (cnt == DELAY_LAST)) begin
            state <= ST_REPEAT;
            cnt   <= '0;
          end else if (cnt != DELAY_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (cnt == PERIOD_LAST) cnt <= '0;
          else                    cnt <= cnt + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign held = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/key_event_pulser.sv
`default_nettype none
// == key_event_pulser : PS/2 key events -> single-cycle W/A/S/D/ENTER pulses with repeat == Rev 1.0
module key_event_pulser
  import key_event_pulser_pkg::*;
#(
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 15_000_000,
  parameter int CNT_W         = 26
) (
  input  logic                clk,
  input  logic                rst,
  key_event_pulser_if.slave   bus
);

  key_vec_t press;
  key_vec_t rel;
  key_vec_t tick;
  key_vec_t held;
  key_vec_t pending;
  key_vec_t grant;
  key_vec_t pulse;

  genvar k;
  generate
    for (k = 0; k < NKEYS; k++) begin : g_key
      localparam logic [8:0] CODE = key_code(k);
      logic hit;

      assign hit      = bus.key_valid && (bus.last_change == CODE);
      assign press[k] = hit && bus.key_down[CODE];
      assign rel[k]   = hit && !bus.key_down[CODE];

      key_repeat_fsm #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
      ) u_fsm (
        .clk    (clk),
        .rst    (rst),
        .press  (press[k]),
        .rel    (rel[k]),
        .rep_en (REPEAT_EN && (k != KIDX_CT)),
        .tick   (tick[k]),
        .held   (held[k])
      );
    end
  endgenerate

  always_comb grant = prio_grant(pending);

  // Only the granted bit is cleared; new ticks merge into whatever is still waiting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      pulse   <= '0;
    end else if (!bus.enable) begin
      pending <= '0;
      pulse   <= '0;
    end else begin
      pending <= (pending & ~grant) | tick;
      pulse   <= grant;
    end
  end

  assign bus.up_pulse = pulse[KIDX_UP];
  assign bus.lt_pulse = pulse[KIDX_LT];
  assign bus.dw_pulse = pulse[KIDX_DW];
  assign bus.rt_pulse = pulse[KIDX_RT];
  assign bus.ct_pulse = pulse[KIDX_CT];
  assign bus.key_held = held;

endmodule
`default_nettype wire

// File: tb/tb_key_event_pulser.sv
`default_nettype none
// == tb_key_event_pulser : directed + random stimulus against a timeline reference model == Rev 1.0
module tb_key_event_pulser;
  import key_event_pulser_pkg::*;

  localparam int D = 20;
  localparam int T = 5;
  localparam logic [8:0] CODES [5] = '{KEY_W, KEY_A, KEY_S, KEY_D, KEY_ENTER};
  localparam int PRIO [5] = '{4, 0, 2, 1, 3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [511:0] kd = '0;
  logic [8:0] lc = '0;
  logic kv = 1'b0;
  logic en = 1'b1;
  int cmps = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  key_event_pulser_if bus0 ();
  key_event_pulser_if bus1 ();

  assign bus0.key_down = kd;
  assign bus0.last_change = lc;
  assign bus0.key_valid = kv;
  assign bus0.enable = en;
  assign bus1.key_down = kd;
  assign bus1.last_change = lc;
  assign bus1.key_valid = kv;
  assign bus1.enable = en;

  key_event_pulser #(.REPEAT_EN(1'b1), .REPEAT_DELAY(D), .REPEAT_PERIOD(T), .CNT_W(26)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  key_event_pulser #(.REPEAT_EN(1'b0), .REPEAT_DELAY(D), .REPEAT_PERIOD(T), .CNT_W(26)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  logic [4:0] p0, p1, h0, h1;
  assign p0 = {bus0.ct_pulse, bus0.rt_pulse, bus0.dw_pulse, bus0.lt_pulse, bus0.up_pulse};
  assign p1 = {bus1.ct_pulse, bus1.rt_pulse, bus1.dw_pulse, bus1.lt_pulse, bus1.up_pulse};
  assign h0 = bus0.key_held;
  assign h1 = bus1.key_held;

  // Reference model: per key, remember when it was pressed and derive ticks from elapsed time.
  logic [4:0] mpend [2] = '{5'd0, 5'd0};
  logic [4:0] mpulse [2] = '{5'd0, 5'd0};
  logic [4:0] mheld [2] = '{5'd0, 5'd0};
  int mt0 [2][5];
  logic [4:0] tk, gr;
  logic pr, rl;
  int age;

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        mpend[i] = '0; mpulse[i] = '0; mheld[i] = '0;
      end else begin
        tk = '0; gr = '0;
        for (int j = 0; j < 5; j++)
          if (gr == 5'd0 && mpend[i][PRIO[j]]) gr[PRIO[j]] = 1'b1;
        for (int k = 0; k < 5; k++) begin
          pr = kv && (lc == CODES[k]) && kd[CODES[k]];
          rl = kv && (lc == CODES[k]) && !kd[CODES[k]];
          if (rl) mheld[i][k] = 1'b0;
          else if (pr && !mheld[i][k]) begin
            mheld[i][k] = 1'b1; mt0[i][k] = cyc; tk[k] = 1'b1;
          end else if (mheld[i][k]) begin
            age = cyc - mt0[i][k];
            if (i == 0 && k != 4 && age >= D && ((age - D) % T) == 0) tk[k] = 1'b1;
          end
        end
        mpulse[i] = en ? gr : 5'd0;
        mpend[i] = en ? ((mpend[i] & ~gr) | tk) : 5'd0;
      end
    end
  end

  logic [19:0] obs, expv;
  assign obs = {h1, p1, h0, p0};
  assign expv = {mheld[1], mpulse[1], mheld[0], mpulse[0]};

  task automatic key_evt(input logic [8:0] code, input logic down);
    kd[code] = down; lc = code; kv = 1'b1;
  endtask

  task automatic test_reset();
    int ups;
    ups = 0;
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      cmps++;
      if (obs !== expv) begin fails++; $display("FAIL reset_model c=%0d got=%h exp=%h", c, obs, expv); end
      if (c < 3) begin
        cmps++;
        if (obs !== 20'd0) begin fails++; $display("FAIL reset_zero c=%0d got=%h exp=0", c, obs); end
      end
      ups += p0[KIDX_UP] + p1[KIDX_UP];
      kv = 1'b0;
      if (c == 0) key_evt(KEY_W, 1'b1);
      if (c == 2) rst = 1'b1;
      if (c == 12) key_evt(KEY_W, 1'b0);
    end
    cmps++;
    if (ups != 0) begin fails++; $display("FAIL reset_no_pulse got=%0d exp=0", ups); end
  endtask

  task automatic test_single_press();
    int n, first;
    n = 0; first = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cmps++;
      if (obs !== expv) begin fails++; $display("FAIL single_model c=%0d got=%h exp=%h", c, obs, expv); end
      if (p0 != 5'd0) begin n++; if (first < 0) first = c; end
      if (c == 2) begin
        cmps++;
        if (h0[KIDX_UP] !== 1'b1) begin fails++; $display("FAIL single_held got=%b exp=1", h0[KIDX_UP]); end
      end
      kv = 1'b0;
      if (c == 0) key_evt(KEY_W, 1'b1);
      if (c == 3) key_evt(KEY_W, 1'b0);
    end
    cmps++;
    if (n != 1 || first != 2) begin fails++; $display("FAIL single_timing got n=%0d at=%0d exp n=1 at=2", n, first); end
    cmps++;
    if (h0 !== 5'd0) begin fails++; $display("FAIL single_released got=%b exp=0", h0); end
  endtask

  task automatic test_hold_repeat();
    int n0, n1, first, last;
    n0 = 0; n1 = 0; first = -1; last = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cmps++;
      if (obs !== expv) begin fails++; $display("FAIL repeat_model c=%0d got=%h exp=%h", c, obs, expv); end
      if (p0[KIDX_RT]) begin n0++; if (first < 0) first = c; last = c; end
      n1 += p1[KIDX_RT];
      kv = 1'b0;
      if (c == 0) key_evt(KEY_D, 1'b1);
      if (c == 40) key_evt(KEY_D, 1'b0);
    end
    cmps++;
    if (n0 != 5 || first != 2 || last != 2 + D + 3 * T) begin
      fails++; $display("FAIL repeat_count got n=%0d first=%0d last=%0d exp n=5 first=2 last=%0d", n0, first, last, 2 + D + 3 * T);
    end
    cmps++;
    if (n1 != 1) begin fails++; $display("FAIL repeat_off_count got=%0d exp=1", n1); end
  endtask

  task automatic test_priority();
    int ct_at, dw_at, both;
    ct_at = -1; dw_at = -1; both = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cmps++;
      if (obs !== expv) begin fails++; $display("FAIL prio_model c=%0d got=%h exp=%h", c, obs, expv); end
      if (p0[KIDX_CT]) ct_at = c;
      if (p0[KIDX_DW]) dw_at = c;
      if (p0[KIDX_CT] && p0[KIDX_DW]) both++;
      kv = 1'b0;
      if (c == 0) key_evt(KEY_ENTER, 1'b1);
      if (c == 1) key_evt(KEY_S, 1'b1);
      if (c == 5) key_evt(KEY_ENTER, 1'b0);
      if (c == 6) key_evt(KEY_S, 1'b0);
    end
    cmps++;
    if (ct_at != 2 || dw_at != 3 || both != 0) begin
      fails++; $display("FAIL prio_order got ct=%0d dw=%0d both=%0d exp ct=2 dw=3 both=0", ct_at, dw_at, both);
    end
  endtask

  task automatic test_no_repeat();
    int ct0, ct1, lt0, lt1;
    ct0 = 0; ct1 = 0; lt0 = 0; lt1 = 0;
    for (int c = 0; c < 180; c++) begin
      @(negedge clk);
      cmps++;
      if (obs !== expv) begin fails++; $display("FAIL norep_model c=%0d got=%h exp=%h", c, obs, expv); end
      ct0 += p0[KIDX_CT]; ct1 += p1[KIDX_CT];
      lt0 += p0[KIDX_LT]; lt1 += p1[KIDX_LT];
      kv = 1'b0;
      if (c == 0) key_evt(KEY_ENTER, 1'b1);
      if (c == 100) key_evt(KEY_ENTER, 1'b0);
      if (c == 105) key_evt(KEY_A, 1'b1);
      if (c == 165) key_evt(KEY_A, 1'b0);
    end
    cmps++;
    if (ct0 != 1 || ct1 != 1) begin fails++; $display("FAIL enter_once got=%0d/%0d exp=1/1", ct0, ct1); end
    cmps++;
    if (lt1 != 1 || lt0 != 9) begin fails++; $display("FAIL a_counts got off=%0d on=%0d exp off=1 on=9", lt1, lt0); end
  endtask

  task automatic test_enable();
    int up_n, up_at;
    up_n = 0; up_at = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cmps++;
      if (obs !== expv) begin fails++; $display("FAIL enable_model c=%0d got=%h exp=%h", c, obs, expv); end
      if (p0[KIDX_UP] || p1[KIDX_UP]) begin up_n++; up_at = c; end
      if (c == 5) begin
        cmps++;
        if (h0[KIDX_UP] !== 1'b1 || p0 !== 5'd0) begin fails++; $display("FAIL enable_off got held=%b pulse=%b exp held=1 pulse=0", h0[KIDX_UP], p0); end
      end
      if (c == 30) begin
        cmps++;
        if (h0 !== 5'd0) begin fails++; $display("FAIL reset_midhold got=%b exp=0", h0); end
      end
      kv = 1'b0;
      if (c == 0) begin en = 1'b0; key_evt(KEY_W, 1'b1); end
      if (c == 10) en = 1'b1;
      if (c == 24) rst = 1'b0;
      if (c == 26) rst = 1'b1;
      if (c == 40) key_evt(KEY_W, 1'b0);
    end
    cmps++;
    if (up_n != 1 || up_at != 2 + D) begin fails++; $display("FAIL enable_tick got n=%0d at=%0d exp n=1 at=%0d", up_n, up_at, 2 + D); end
  endtask

  task automatic test_random();
    int j;
    logic [8:0] code;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      cmps++;
      if (obs !== expv) begin fails++; $display("FAIL random_model c=%0d got=%h exp=%h", c, obs, expv); end
      kv = 1'b0;
      en = ($urandom_range(0, 15) != 0);
      if (c >= 560) begin
        en = 1'b1;
        if (c < 565 && kd[CODES[c - 560]]) key_evt(CODES[c - 560], 1'b0);
      end else if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, 5);
        code = (j < 5) ? CODES[j] : 9'h029;
        if (kd[code] && $urandom_range(0, 3) != 0) key_evt(code, 1'b0);
        else key_evt(code, 1'b1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_priority();
    test_no_repeat();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
`default_nettype wire
